hdmi_island_sched: RTL and testbench

Per-line data-island packet scheduler for the HDMI transmitter. On each line start it chooses which packets fill the line's fixed number of island slots: audio samples first, then the periodic Audio Clock Regeneration packet, then at most one pending InfoFrame, with null packets in any remaining slot. It presents the packets one at a time over a valid/ready handshake to the packet serializer. It also owns the audio sample pop strobe and the 192-frame IEC60958 channel-status counter.

---
 rtl/hdmi_island_sched.sv | 192 +++++++++++++++++++
 tb/tb_hdmi_island_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hdmi_island_sched.sv
// hdmi_island_sched
// Per-line data-island packet scheduler. On each line start it plans the
// line's SLOTS island packets (audio, then ACR, then one InfoFrame, then
// nulls) and hands them one by one to the packet serializer over a
// valid/ready handshake. It also owns the audio pop strobe and the 192-frame
// IEC60958 channel-status counter.
//
// Optional build macro: HDMI_SPD_EN adds the SPD InfoFrame (type 4) between
// AVI and AIF. Without it, type 4 is never emitted.
//
// Ports:
//   clk, rst_n      pixel clock, async active-low reset
//   line_start      one-cycle pulse at HSYNC rise
//   frame_start     one-cycle pulse at VSYNC rise, requests InfoFrames
//   run             scheduling enable, sampled at line_start
//   aud_level[1:0]  audio samples available (3 counts as 2)
//   aud_pop         one pulse per audio-sample handshake
//   pkt_valid/ready descriptor handshake with the serializer
//   pkt_type[2:0]   0 null, 1 audio, 2 ACR, 3 AVI, 4 SPD, 5 AIF
//   pkt_slot[1:0]   slot index in the line; pkt_last marks slot SLOTS-1
//   csb[7:0]        channel-status bit index; b_frame = (csb == 0)
//   err_overrun     sticky, line_start arrived while a line was in flight
//
// state | meaning
// IDLE  | waiting for line_start
// PLAN  | one cycle, latch the line's slot plan and slot 0 descriptor
// ISSUE | present descriptors, advance one slot per handshake
module hdmi_island_sched #(
   parameter int ACR_PERIOD = 45,
   parameter int SLOTS      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       line_start,
   input  logic       frame_start,
   input  logic       run,
   input  logic [1:0] aud_level,
   output logic       aud_pop,
   output logic       pkt_valid,
   input  logic       pkt_ready,
   output logic [2:0] pkt_type,
   output logic [1:0] pkt_slot,
   output logic       pkt_last,
   output logic [7:0] csb,
   output logic       b_frame,
   output logic       err_overrun
);

   typedef enum logic [1:0] {IDLE, PLAN, ISSUE} state_t;

   localparam logic [2:0] T_NULL = 3'd0;
   localparam logic [2:0] T_AUD  = 3'd1;
   localparam logic [2:0] T_ACR  = 3'd2;
   localparam logic [2:0] T_AVI  = 3'd3;
   localparam logic [2:0] T_SPD  = 3'd4;
   localparam logic [2:0] T_AIF  = 3'd5;

   localparam logic [2:0] SLOTS_W   = 3'(SLOTS);
   localparam logic [1:0] LAST_SLOT = 2'(SLOTS - 1);
   localparam logic [1:0] NA_MAX    = (SLOTS < 2) ? 2'(SLOTS) : 2'd2;
   localparam logic [5:0] LC_WRAP   = 6'(ACR_PERIOD - 1);

   state_t     state, state_nxt;
   logic       hs;
   logic [5:0] line_cnt;
   logic       acr_pend, acr_due;
   logic       pend_avi, pend_spd, pend_aif;
   logic [1:0] na_q;
   logic       acr_q;
   logic [2:0] if_q;

   logic [1:0] lvl, na_c;
   logic       acr_c;
   logic [2:0] used_c, if_c;
   logic [1:0] slot_nxt;

   assign pkt_valid = (state == ISSUE);
   assign hs        = pkt_valid & pkt_ready;
   assign aud_pop   = hs & (pkt_type == T_AUD);
   assign b_frame   = (csb == 8'd0);
   assign slot_nxt  = pkt_slot + 2'd1;

   function automatic logic [2:0] slot_type(input logic [1:0] idx, input logic [1:0] n_aud,
                                            input logic acr, input logic [2:0] ift);
      logic [2:0] t;
      t = T_NULL;
      if (idx < n_aud)
         t = T_AUD;
      else if (acr && (idx == n_aud))
         t = T_ACR;
      else if ((ift != T_NULL) && ({1'b0, idx} == ({1'b0, n_aud} + {2'b0, acr})))
         t = ift;
      return t;
   endfunction

   always_comb begin
      lvl    = (aud_level == 2'd3) ? 2'd2 : aud_level;
      na_c   = (lvl < NA_MAX) ? lvl : NA_MAX;
      acr_c  = acr_due & ({1'b0, na_c} < SLOTS_W);
      used_c = {1'b0, na_c} + {2'b0, acr_c};
      if_c   = T_NULL;
      if (used_c < SLOTS_W) begin
         if (pend_avi)      if_c = T_AVI;
         else if (pend_spd) if_c = T_SPD;
         else if (pend_aif) if_c = T_AIF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (line_start && run) state_nxt = PLAN;
         PLAN:    state_nxt = ISSUE;
         ISSUE:   if (hs && pkt_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_cnt    <= 6'd0;
         acr_pend    <= 1'b1;
         acr_due     <= 1'b0;
         pend_avi    <= 1'b0;
         pend_aif    <= 1'b0;
         na_q        <= 2'd0;
         acr_q       <= 1'b0;
         if_q        <= T_NULL;
         pkt_type    <= T_NULL;
         pkt_slot    <= 2'd0;
         pkt_last    <= 1'b0;
         csb         <= 8'd0;
         err_overrun <= 1'b0;
      end else begin
         if (line_start) begin
            line_cnt <= (line_cnt == LC_WRAP) ? 6'd0 : line_cnt + 6'd1;
            if (state != IDLE) err_overrun <= 1'b1;
         end

         // The line sees acr_pend as it stood at its own pulse, so the wrap
         // on the pulse of line ACR_PERIOD-1 makes the ACR due on the next line.
         if (line_start && (state == IDLE)) acr_due <= acr_pend;

         if (hs && (pkt_type == T_ACR)) acr_pend <= 1'b0;
         if (line_start && (line_cnt == LC_WRAP)) acr_pend <= 1'b1;

         if (hs && (pkt_type == T_AVI)) pend_avi <= 1'b0;
         if (frame_start) pend_avi <= 1'b1;
         if (hs && (pkt_type == T_AIF)) pend_aif <= 1'b0;
         if (frame_start) pend_aif <= 1'b1;

         if (aud_pop) csb <= (csb == 8'd191) ? 8'd0 : csb + 8'd1;

         if (state == PLAN) begin
            na_q     <= na_c;
            acr_q    <= acr_c;
            if_q     <= if_c;
            pkt_slot <= 2'd0;
            pkt_type <= slot_type(2'd0, na_c, acr_c, if_c);
            pkt_last <= (LAST_SLOT == 2'd0);
         end else if (hs) begin
            if (pkt_last) begin
               pkt_slot <= 2'd0;
               pkt_type <= T_NULL;
               pkt_last <= 1'b0;
            end else begin
               pkt_slot <= slot_nxt;
               pkt_type <= slot_type(slot_nxt, na_q, acr_q, if_q);
               pkt_last <= (slot_nxt == LAST_SLOT);
            end
         end
      end
   end

`ifdef HDMI_SPD_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_spd <= 1'b0;
      else begin
         if (hs && (pkt_type == T_SPD)) pend_spd <= 1'b0;
         if (frame_start) pend_spd <= 1'b1;
      end
   end
`else
   assign pend_spd = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_island_sched.sv
module tb_hdmi_island_sched;

`ifdef HDMI_SPD_EN
   localparam bit SPD = 1'b1;
`else
   localparam bit SPD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       line_start = 1'b0, frame_start = 1'b0, run = 1'b0;
   logic [1:0] aud_level = 2'd0;
   logic       pkt_ready = 1'b1;
   logic       aud_pop, pkt_valid, pkt_last, b_frame, err_overrun;
   logic [2:0] pkt_type;
   logic [1:0] pkt_slot;
   logic [7:0] csb;

   hdmi_island_sched dut (
      .clk(clk), .rst_n(rst_n), .line_start(line_start), .frame_start(frame_start),
      .run(run), .aud_level(aud_level), .aud_pop(aud_pop), .pkt_valid(pkt_valid),
      .pkt_ready(pkt_ready), .pkt_type(pkt_type), .pkt_slot(pkt_slot),
      .pkt_last(pkt_last), .csb(csb), .b_frame(b_frame), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [1:0] aud;
      logic       frm;
      logic [2:0] e0, e1, e2;
   } vec_t;

   localparam int NV = 93;
   vec_t tbl[NV];

   int n_cmp = 0;
   int n_bad = 0;
   int cur_line = 0;
   int model_csb = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s line %0d: got %0d expected %0d", nm, cur_line, act, exp);
      end
   endtask

   task automatic chk_aud(input logic [2:0] t);
      if (t == 3'd1) begin
         chk("csb", csb, model_csb);
         chk("b_frame", b_frame, (model_csb == 0) ? 1 : 0);
         model_csb = (model_csb == 191) ? 0 : model_csb + 1;
      end
   endtask

   task automatic do_line(input logic r, input logic [1:0] aud, input logic frm,
                          input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2);
      logic [2:0] e[3];
      e[0] = e0; e[1] = e1; e[2] = e2;
      @(negedge clk);
      line_start = 1'b1; frame_start = frm; run = r; aud_level = aud;
      @(negedge clk);
      line_start = 1'b0; frame_start = 1'b0; #1;
      chk("plan_valid", pkt_valid, 0);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk); #1;
         if (r) begin
            chk("valid", pkt_valid, 1);
            chk("type", pkt_type, e[s]);
            chk("slot", pkt_slot, s);
            chk("last", pkt_last, (s == 2) ? 1 : 0);
            chk("aud_pop", aud_pop, (e[s] == 3'd1) ? 1 : 0);
            chk_aud(e[s]);
         end else begin
            chk("norun_valid", pkt_valid, 0);
         end
      end
      @(negedge clk); #1;
      chk("idle_valid", pkt_valid, 0);
      cur_line++;
   endtask

   initial begin
      // Default line: one sample, no ACR, no InfoFrame.
      for (int i = 0; i < NV; i++) tbl[i] = '{1'b1, 2'd1, 1'b0, 3'd1, 3'd0, 3'd0};
      tbl[0]  = '{1'b1, 2'd2, 1'b0, 3'd1, 3'd1, 3'd2};
      tbl[45] = '{1'b1, 2'd1, 1'b0, 3'd1, 3'd2, 3'd0};
      tbl[46] = '{1'b1, 2'd2, 1'b1, 3'd1, 3'd1, 3'd3};
      tbl[47] = '{1'b1, 2'd2, 1'b0, 3'd1, 3'd1, SPD ? 3'd4 : 3'd5};
      tbl[48] = '{1'b1, 2'd2, 1'b0, 3'd1, 3'd1, SPD ? 3'd5 : 3'd0};
      tbl[49] = '{1'b1, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0};
      tbl[50] = '{1'b1, 2'd3, 1'b0, 3'd1, 3'd1, 3'd0};
      tbl[51] = '{1'b0, 2'd2, 1'b0, 3'd0, 3'd0, 3'd0};
      tbl[90] = '{1'b1, 2'd2, 1'b0, 3'd1, 3'd1, 3'd2};
      tbl[91] = '{1'b1, 2'd0, 1'b1, 3'd3, 3'd0, 3'd0};
      tbl[92] = '{1'b1, 2'd1, 1'b0, 3'd1, SPD ? 3'd4 : 3'd5, 3'd0};

      #23; #1;
      chk("rst_valid", pkt_valid, 0);
      chk("rst_type", pkt_type, 0);
      chk("rst_slot", pkt_slot, 0);
      chk("rst_last", pkt_last, 0);
      chk("rst_pop", aud_pop, 0);
      chk("rst_csb", csb, 0);
      chk("rst_b_frame", b_frame, 1);
      chk("rst_overrun", err_overrun, 0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++)
         do_line(tbl[i].r, tbl[i].aud, tbl[i].frm, tbl[i].e0, tbl[i].e1, tbl[i].e2);

      // Line 93: stall 5 cycles on slot 1.
      @(negedge clk);
      line_start = 1'b1; run = 1'b1; aud_level = 2'd2;
      @(negedge clk); line_start = 1'b0;
      @(negedge clk); #1;
      chk("st_type0", pkt_type, 1);
      chk_aud(3'd1);
      @(negedge clk);
      pkt_ready = 1'b0; #1;
      chk("st_slot1", pkt_slot, 1);
      chk("st_pop_low", aud_pop, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 4) pkt_ready = 1'b1;
         #1;
         chk("st_hold_valid", pkt_valid, 1);
         chk("st_hold_type", pkt_type, 1);
         chk("st_hold_slot", pkt_slot, 1);
         chk("st_hold_csb", csb, model_csb);
         chk("st_pop", aud_pop, (k == 4) ? 1 : 0);
      end
      chk_aud(3'd1);
      @(negedge clk); #1;
      chk("st_slot2", pkt_slot, 2);
      chk("st_type2", pkt_type, SPD ? 5 : 0);
      chk("st_last", pkt_last, 1);
      @(negedge clk); #1;
      chk("st_idle", pkt_valid, 0);
      cur_line++;

      // Lines 94..148: two samples each, ACR on line 135; csb wraps.
      for (int p = 94; p < 149; p++)
         do_line(1'b1, 2'd2, 1'b0, 3'd1, 3'd1, (p % 45 == 0) ? 3'd2 : 3'd0);

      // Line 149 interrupted by a second pulse while issuing slot 0.
      chk("pre_overrun", err_overrun, 0);
      @(negedge clk);
      line_start = 1'b1; aud_level = 2'd1;
      @(negedge clk); line_start = 1'b0;
      @(negedge clk);
      line_start = 1'b1; #1;
      chk("ov_type0", pkt_type, 1);
      chk_aud(3'd1);
      @(negedge clk);
      line_start = 1'b0; #1;
      chk("ov_flag", err_overrun, 1);
      chk("ov_slot1", pkt_slot, 1);
      chk("ov_type1", pkt_type, 0);
      @(negedge clk); #1;
      chk("ov_slot2", pkt_slot, 2);
      chk("ov_last", pkt_last, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk("ov_no_line", pkt_valid, 0);
      end
      chk("ov_sticky", err_overrun, 1);
      cur_line += 2;

      // Line 151: reset asserted mid-ISSUE.
      @(negedge clk);
      line_start = 1'b1; aud_level = 2'd1;
      @(negedge clk); line_start = 1'b0;
      @(negedge clk); #1;
      chk("rm_valid_pre", pkt_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rm_valid", pkt_valid, 0);
      chk("rm_overrun", err_overrun, 0);
      chk("rm_csb", csb, 0);
      chk("rm_b_frame", b_frame, 1);
      #10 rst_n = 1'b1;
      model_csb = 0;
      cur_line = 0;
      do_line(1'b1, 2'd2, 1'b0, 3'd1, 3'd1, 3'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
